// File: rtl/nonrestoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : nonrestoring_divider
// Description : Multi-cycle signed divider using the non-restoring algorithm
//               on operand magnitudes, with a final sign/remainder fix-up.
//               Results truncate toward zero; the remainder takes the sign
//               of the dividend. A zero divisor is flagged and bypasses the
//               iteration.
//
// Ports       : clk         - clock, rising edge
//               rst         - synchronous active-high reset
//               start       - operation request, honoured only when idle
//               dividend    - signed dividend, captured on accepted start
//               divisor     - signed divisor, captured on accepted start
//               busy        - iteration / fix-up in progress
//               done        - one-cycle pulse, results valid
//               quotient    - signed quotient (held until next completion)
//               remainder   - signed remainder (held until next completion)
//               div_by_zero - last completed operation had a zero divisor
//
// Revision    : 1.0 - initial release
// ============================================================================
module nonrestoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Counter holds the index of the current step, 0 .. WIDTH-1.
    localparam int              c_CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST     = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    state_t           r_state;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH:0]   r_rem;     // one extra bit so 2*rem +/- d never overflows
    logic [WIDTH-1:0] r_q;       // dividend magnitude shifts out, quotient shifts in
    logic [WIDTH-1:0] r_dmag;
    logic             r_neg_q;
    logic             r_neg_r;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_d_ext;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_rem_step;
    logic [WIDTH-1:0] w_q_step;
    logic [WIDTH:0]   w_rem_fix;
    logic [WIDTH-1:0] w_q_fin;
    logic [WIDTH-1:0] w_r_fin;

    // Magnitudes as unsigned WIDTH-bit values; the most negative number
    // maps onto 2^(WIDTH-1), which is still representable unsigned.
    assign w_a_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign w_b_mag = divisor[WIDTH-1]  ? -divisor  : divisor;

    assign w_d_ext    = {1'b0, r_dmag};
    assign w_rem_sh   = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_rem_step = r_rem[WIDTH] ? (w_rem_sh + w_d_ext) : (w_rem_sh - w_d_ext);
    assign w_q_step   = {r_q[WIDTH-2:0], ~w_rem_step[WIDTH]};

    // Final correction: a negative partial remainder is restored once.
    assign w_rem_fix = r_rem[WIDTH] ? (r_rem + w_d_ext) : r_rem;
    assign w_q_fin   = r_neg_q ? -r_q : r_q;
    assign w_r_fin   = r_neg_r ? -w_rem_fix[WIDTH-1:0] : w_rem_fix[WIDTH-1:0];

    assign busy = (r_state == S_CALC) || (r_state == S_FIX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_dmag      <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            // done is a registered image of the DONE state, so it rises one
            // edge after the state is entered and lasts exactly one cycle.
            done <= (r_state == S_DONE);

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_rem   <= '0;
                            r_q     <= w_a_mag;
                            r_dmag  <= w_b_mag;
                            r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            r_neg_r <= dividend[WIDTH-1];
                            r_cnt   <= '0;
                            r_state <= S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    r_rem <= w_rem_step;
                    r_q   <= w_q_step;
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_LAST) begin
                        r_state <= S_FIX;
                    end
                end

                S_FIX: begin
                    quotient    <= w_q_fin;
                    remainder   <= w_r_fin;
                    div_by_zero <= 1'b0;
                    r_state     <= S_DONE;
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nonrestoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_nonrestoring_divider
// Description : Self-checking bench for nonrestoring_divider (WIDTH = 8).
//               Directed vector table plus hand-written sequences for
//               ignored start, reset override and mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nonrestoring_divider;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int total;
    int bad;
    int done_cnt;

    nonrestoring_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial done_cnt = 0;
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         lat;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one operation and wait (bounded) for its done pulse.
    task automatic run_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic edz, input int elat);
        int  n;
        bit  seen;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        cycle();
        start = 1'b0;
        check({nm, "_busy"}, 32'(busy), 32'(b != 8'h00));
        n    = 0;
        seen = 0;
        while (!seen && n < 40) begin
            if (done === 1'b1) seen = 1;
            else begin
                cycle();
                n++;
            end
        end
        check({nm, "_lat"}, 32'(n), 32'(elat));
        check({nm, "_q"}, 32'(quotient), 32'(eq));
        check({nm, "_r"}, 32'(remainder), 32'(er));
        check({nm, "_dz"}, 32'(div_by_zero), 32'(edz));
        cycle();
        check({nm, "_pulse"}, 32'(done), 32'd0);
        check({nm, "_hold"}, 32'({quotient, remainder}), 32'({eq, er}));
    endtask

    initial begin
        int base;
        int n;

        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        //            a      b      q      r     dz lat
        vecs[0]  = '{8'd100, 8'd7,  8'h0E, 8'h02, 1'b0, 10};
        vecs[1]  = '{8'h9C, 8'd7,  8'hF2, 8'hFE, 1'b0, 10};
        vecs[2]  = '{8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 10};
        vecs[3]  = '{8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 10};
        vecs[4]  = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 10};
        vecs[5]  = '{8'h37, 8'h00, 8'hFF, 8'h37, 1'b1, 1};
        vecs[6]  = '{8'h7F, 8'h01, 8'h7F, 8'h00, 1'b0, 10};
        vecs[7]  = '{8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 10};
        vecs[8]  = '{8'h80, 8'h00, 8'hFF, 8'h80, 1'b1, 1};
        vecs[9]  = '{8'd7,  8'd100, 8'h00, 8'h07, 1'b0, 10};
        vecs[10] = '{8'hF9, 8'd100, 8'h00, 8'hF9, 1'b0, 10};
        vecs[11] = '{8'h80, 8'h7F, 8'hFF, 8'hFF, 1'b0, 10};
        vecs[12] = '{8'h00, 8'd5,  8'h00, 8'h00, 1'b0, 10};
        vecs[13] = '{8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0, 10};
        vecs[14] = '{8'h80, 8'h80, 8'h01, 8'h00, 1'b0, 10};
        vecs[15] = '{8'hFF, 8'h02, 8'h00, 8'hFF, 1'b0, 10};
        vecs[16] = '{8'h7F, 8'h7F, 8'h01, 8'h00, 1'b0, 10};
        vecs[17] = '{8'h00, 8'h00, 8'hFF, 8'h00, 1'b1, 1};

        // Reset state
        cycle();
        cycle();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        check("rst_dz", 32'(div_by_zero), 32'd0);

        // Reset wins over a start on the same edge
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        cycle();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_busy", 32'(busy), 32'd0);
        base = done_cnt;
        for (int i = 0; i < 14; i++) cycle();
        check("rst_start_nodone", 32'(done_cnt - base), 32'd0);

        // Directed vector table
        for (int i = 0; i < 18; i++) begin
            run_op($sformatf("v%0d", i), vecs[i].a, vecs[i].b, vecs[i].q,
                   vecs[i].r, vecs[i].dz, vecs[i].lat);
        end

        // Start in CALC ignored; operands wiggling while busy ignored
        base = done_cnt;
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        cycle();                 // accept edge -> CALC cycle 1
        start = 1'b0;
        cycle();                 // CALC cycle 2
        cycle();                 // CALC cycle 3
        dividend = 8'h37;
        divisor  = 8'h00;
        start    = 1'b1;
        cycle();
        start    = 1'b0;
        dividend = 8'h80;
        divisor  = 8'hFF;
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            cycle();
            n++;
        end
        check("ign_lat", 32'(n + 3), 32'd10);
        check("ign_q", 32'(quotient), 32'h0E);
        check("ign_r", 32'(remainder), 32'h02);
        check("ign_dz", 32'(div_by_zero), 32'd0);
        for (int i = 0; i < 15; i++) cycle();
        check("ign_pulses", 32'(done_cnt - base), 32'd1);

        // Reset in CALC cycle 4 aborts without a done pulse
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'hF9;
        start    = 1'b1;
        cycle();                 // CALC cycle 1
        start = 1'b0;
        cycle();                 // 2
        cycle();                 // 3
        cycle();                 // 4
        check("abort_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_q", 32'(quotient), 32'd0);
        check("abort_r", 32'(remainder), 32'd0);
        check("abort_dz", 32'(div_by_zero), 32'd0);
        base = done_cnt;
        for (int i = 0; i < 15; i++) cycle();
        check("abort_nodone", 32'(done_cnt - base), 32'd0);
        run_op("after_abort", 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
